// File: rtl/acq_sequencer_if.sv
// Frame readout stream between the acquisition sequencer and its consumer.
// Plain valid/ready: a word moves on any clock where Rd_Valid_o and Rd_Ready_i are both high.
// Names carry the sequencer-side direction; the master modport belongs to the sequencer.
interface acq_sequencer_if #(
  parameter int NBITS = 4
);
  logic             Rd_Valid_o;
  logic             Rd_Ready_i;
  logic [NBITS-1:0] Rd_Data_o;
  logic             Rd_Last_o;

  modport master (output Rd_Valid_o, output Rd_Data_o, output Rd_Last_o, input Rd_Ready_i);
  modport slave  (input Rd_Valid_o, input Rd_Data_o, input Rd_Last_o, output Rd_Ready_i);
endinterface

// File: rtl/acq_sequencer.sv
// Run controller for the coincidence detector: clear, gated window, snapshot, frame readout, repeat.
// Latency: Restart one clock after Start; first frame word one clock after the snapshot cycle.
// Backpressure: readout holds word/Last while Rd_Ready_i is low; Abort_i always wins and discards the frame.
module acq_sequencer #(
  parameter int NCHAN    = 4,
  parameter int NBITS    = 4,
  parameter int NRUNBITS = 8
) (
  input  logic                                  Clk,
  input  logic                                  Reset_n,
  input  logic                                  Start_i,
  input  logic                                  Abort_i,
  input  logic [NBITS-1:0]                      Cfg_nCycles_i,
  input  logic [NRUNBITS-1:0]                   Cfg_nRuns_i,
  output logic                                  Det_Restart_o,
  output logic                                  Det_Enable_o,
  output logic [NBITS-1:0]                      Det_nCycles_o,
  input  logic [NBITS-1:0]                      Det_CntClk_i,
  input  logic [NCHAN*NBITS-1:0]                Det_CntChann_i,
  input  logic [(NCHAN*(NCHAN-1)/2)*NBITS-1:0]  Det_CntPairs_i,
  acq_sequencer_if.master                       rd,
  output logic                                  Busy_o,
  output logic                                  Done_o,
  output logic [NRUNBITS-1:0]                   RunCnt_o
);

  localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2;
  localparam int NWORDS = NCHAN + NPAIRS;
  localparam int IDXW   = $clog2(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_ACQ, S_SNAP, S_READ, S_FIN, S_ABORT
  } state_t;

  state_t                    state_q, state_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic                      settle_q, settle_d;
  logic [NBITS-1:0]          ncyc_q;
  logic [NRUNBITS-1:0]       nruns_q;
  logic [NRUNBITS-1:0]       runcnt_q;
  logic [NWORDS*NBITS-1:0]   shadow_q;
  logic                      restart_q, enable_q, valid_q, last_q, busy_q, done_q;
  logic [NBITS-1:0]          data_q;

  logic                      last_xfer;
  logic                      more_runs;
  logic [NWORDS*NBITS-1:0]   frame_w;
  logic [NBITS-1:0]          rd_word;

  // Next-state, word index and end-of-frame decision; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    last_xfer = 1'b0;
    more_runs = (nruns_q == '0) ||
                (({1'b0, runcnt_q} + (NRUNBITS+1)'(1)) < {1'b0, nruns_q});
    case (state_q)
      S_IDLE:   if (Start_i && !Abort_i) state_d = S_CLEAR;
      S_CLEAR:  begin state_d = S_SETTLE; settle_d = 1'b0; end
      S_SETTLE: if (settle_q) state_d = S_ACQ; else settle_d = 1'b1;
      S_ACQ:    if (Det_CntClk_i == ncyc_q) state_d = S_SNAP;
      S_SNAP:   begin state_d = S_READ; idx_d = '0; end
      S_READ: begin
        if (valid_q && rd.Rd_Ready_i) begin
          if (idx_q == LAST_IDX) begin
            last_xfer = 1'b1;
            idx_d     = '0;
            state_d   = more_runs ? S_CLEAR : S_FIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FIN:    state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && Abort_i) begin
      state_d   = S_ABORT;
      idx_d     = '0;
      last_xfer = 1'b0;
    end
  end

  // During SNAP the live counters are the frame (the shadow loads on the same edge); afterwards the shadow is.
  always_comb begin
    frame_w = (state_q == S_SNAP) ? {Det_CntPairs_i, Det_CntChann_i} : shadow_q;
    rd_word = frame_w[idx_d*NBITS +: NBITS];
  end

  // Sequencer state, latched config, run counter and all registered outputs decoded from the next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      settle_q  <= 1'b0;
      ncyc_q    <= '0;
      nruns_q   <= '0;
      runcnt_q  <= '0;
      restart_q <= 1'b0;
      enable_q  <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      if (state_q == S_IDLE && state_d == S_CLEAR) begin
        ncyc_q   <= Cfg_nCycles_i;
        nruns_q  <= Cfg_nRuns_i;
        runcnt_q <= '0;
      end else if (last_xfer) begin
        runcnt_q <= runcnt_q + 1'b1;
      end
      restart_q <= (state_d == S_CLEAR) || (state_d == S_ABORT);
      enable_q  <= (state_d == S_ACQ);
      valid_q   <= (state_d == S_READ);
      last_q    <= (state_d == S_READ) && (idx_d == LAST_IDX);
      data_q    <= (state_d == S_READ) ? rd_word : '0;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_FIN);
    end
  end

  // Snapshot of every channel and pair counter, frozen for the whole readout.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_q <= '0;
    end else if (state_q == S_SNAP) begin
      shadow_q <= {Det_CntPairs_i, Det_CntChann_i};
    end
  end

  assign Det_Restart_o = restart_q;
  assign Det_Enable_o  = enable_q;
  assign Det_nCycles_o = ncyc_q;
  assign rd.Rd_Valid_o = valid_q;
  assign rd.Rd_Data_o  = data_q;
  assign rd.Rd_Last_o  = last_q;
  assign Busy_o        = busy_q;
  assign Done_o        = done_q;
  assign RunCnt_o      = runcnt_q;

endmodule
